pipe_adder: RTL
===============

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/sum width in bits, legal range 1..64.
REQ-002 SHALL have parameter LATENCY, default 3, number of pipeline register stages, legal range 1..8.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand set a/b/ci present.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand set this cycle.
REQ-007 SHALL have port a  input  WIDTH  addend.
REQ-008 SHALL have port b  input  WIDTH  addend.
REQ-009 SHALL have port ci  input  1  carry in.
REQ-010 SHALL have port out_valid  output  1  sum/co hold a valid result.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result this cycle.
REQ-012 SHALL have port sum  output  WIDTH  result bits [WIDTH-1:0].
REQ-013 SHALL have port co  output  1  carry out, bit WIDTH of a+b+ci.
REQ-014 SHALL have port occ  output  4  count of valid pipeline stages, 0..LATENCY.

Function
REQ-015 SHALL compute a+b+ci at WIDTH+1 bits, zero-extended; {co,sum} = full result, no truncation before the carry bit.
REQ-016 SHALL accept an operand set on a rising edge where in_valid && in_ready (acceptance edge N), capturing it into stage 1.
REQ-017 SHALL, with no stalls, present the result with out_valid=1 in the cycle after edge N+LATENCY-1; LATENCY=1 gives out_valid the cycle after acceptance.
REQ-018 SHALL transfer a result on a rising edge where out_valid && out_ready; out_valid, sum and co SHALL hold stable while out_valid && !out_ready.
REQ-019 SHALL advance each stage independently: stage k loads from stage k-1 when stage k is empty or stage k is itself advancing (bubble collapse).
REQ-020 SHALL drive in_ready = !stage1_valid || stage1_advancing; combinational from out_ready permitted only through this chain.
REQ-021 SHALL, when full and out_ready=1, accept a new operand and emit a result on the same edge (throughput 1/cycle, occ unchanged).
REQ-022 SHALL, when full and out_ready=0, hold in_ready=0 and drop nothing; operands presented meanwhile are not captured.
REQ-023 SHALL preserve result order equal to acceptance order under all stall patterns.
REQ-024 SHALL update occ as occ + accept - emit on every edge; never exceed LATENCY nor underflow.
REQ-025 SHALL ignore a, b, ci when in_valid=0; no stage state changes from them.

Reset
REQ-026 SHALL on rst_n=0 immediately clear all stage valid bits; out_valid=0, occ=0, sum=0, co=0, in_ready=0 while asserted.
REQ-027 SHALL discard all in-flight results on reset mid-operation; none emerge after deassertion.
REQ-028 SHALL assert in_ready on the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL, with macro PIPE_ADDER_SAT_EN defined, saturate: when the full result exceeds 2^WIDTH-1, sum = all ones and co = 1.
REQ-030 SHALL, without PIPE_ADDER_SAT_EN, wrap: sum = result mod 2^WIDTH, co = bit WIDTH; latency and handshake identical in both builds.

Verification
REQ-031 SHALL cover WIDTH=4, LATENCY=3, out_ready=1: a=4'h7,b=4'h8,ci=1 accepted at edge 0 -> out_valid in cycle after edge 2, sum=4'h0, co=1 (wrap build).
REQ-032 SHALL cover same stimulus with PIPE_ADDER_SAT_EN -> sum=4'hF, co=1; a=3,b=4,ci=0 -> sum=7, co=0.
REQ-033 SHALL cover back-to-back 10 operands, out_ready=1 -> 10 results in order on 10 consecutive cycles, occ steady at 3.
REQ-034 SHALL cover out_ready=0 with continuous in_valid -> exactly 3 accepted, in_ready=0, occ=3; release out_ready -> 3 results in order, then streaming resumes.
REQ-035 SHALL cover out_ready toggling 1,0,1,0 with in_valid random -> scoreboard matches every result, none lost or duplicated.
REQ-036 SHALL cover rst_n asserted with occ=2 -> out_valid=0, occ=0 immediately; no stale result after release.

Source files
------------

// File: rtl/pipe_adder.sv
// pipe_adder: elastic pipelined adder producing {co,sum} = a + b + ci.
// LATENCY register stages with per-stage valid bits and bubble collapse, so
// each stage advances independently. Results leave in acceptance order.
// Build option: define PIPE_ADDER_SAT_EN to saturate the sum to all ones
// (co = 1) on overflow instead of wrapping.
module pipe_adder #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic [3:0]       occ
);

    // Full-width add; the carry bit is kept as bit WIDTH of the result.
    function automatic logic [WIDTH:0] add_fn(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             c);
        logic [WIDTH:0] full;
        full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
`ifdef PIPE_ADDER_SAT_EN
        if (full[WIDTH]) begin
            full = {1'b1, {WIDTH{1'b1}}};
        end
`endif
        return full;
    endfunction

    // Number of occupied stages.
    function automatic logic [3:0] count_fn(input logic [LATENCY-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < LATENCY; k++) begin
            n = n + {3'b000, v[k]};
        end
        return n;
    endfunction

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;
    logic [LATENCY-1:0] adv;
    logic [LATENCY-1:0] load;
    logic [LATENCY:0]   free;
    logic               in_ready_w;
    logic [WIDTH:0]     res_q [LATENCY];

    // Handshake chain: a stage advances when it holds data and the stage after
    // it can take data; a stage can take data when empty or itself advancing.
    always_comb begin
        free          = '0;
        adv           = '0;
        load          = '0;
        vld_d         = vld_q;
        free[LATENCY] = out_ready;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            adv[k]  = vld_q[k] & free[k+1];
            free[k] = ~vld_q[k] | adv[k];
        end
        in_ready_w = rst_n & free[0];
        load[0]    = in_valid & in_ready_w;
        for (int k = 1; k < LATENCY; k++) begin
            load[k] = adv[k-1];
        end
        for (int k = 0; k < LATENCY; k++) begin
            vld_d[k] = load[k] | (vld_q[k] & ~adv[k]);
        end
    end

    // Stage valid bits; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Stage data: stage 0 captures the new sum, later stages copy from the
    // previous stage only when it hands over.
    always_ff @(posedge clk) begin
        if (load[0]) begin
            res_q[0] <= add_fn(a, b, ci);
        end
        for (int k = 1; k < LATENCY; k++) begin
            if (load[k]) begin
                res_q[k] <= res_q[k-1];
            end
        end
    end

    assign in_ready  = in_ready_w;
    assign out_valid = vld_q[LATENCY-1];
    // Data outputs read as zero whenever no result is presented (incl. reset).
    assign sum       = out_valid ? res_q[LATENCY-1][WIDTH-1:0] : '0;
    assign co        = out_valid & res_q[LATENCY-1][WIDTH];
    assign occ       = count_fn(vld_q);

endmodule
